trap_ctrl: RTL and testbench

- Machine-mode trap sequencer between the commit point of the pipeline and the mcsr register block.
- Arbitrates synchronous exceptions, asynchronous interrupts (external, software, timer) and mret.
- Drives the mcsr hardware write ports: mepc, mcause, mtval and mstatus mie/mpie/mpp.
- Issues a pipeline flush and a PC redirect to the trap vector, or to mepc on mret.

---
 rtl/trap_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and mret at commit,
// drives mcsr write pulses, flush and PC redirect. Optional macro: TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr_pc,
  input  logic        i_exc_valid,
  input  logic [3:0]  i_exc_code,
  input  logic [31:0] i_exc_tval,
  input  logic        i_mret,
  input  logic        i_external_irq,
  input  logic        i_software_irq,
  input  logic        i_timer_irq,
  input  logic        i_meie,
  input  logic        i_msie,
  input  logic        i_mtie,
  input  logic        i_mstatus_mie,
  input  logic        i_mstatus_mpie,
  input  logic [29:0] i_mtvec_base,
  input  logic [1:0]  i_mtvec_mode,
  input  logic [31:0] i_mepc_value,
  output logic [31:0] o_mepc_value,
  output logic        o_mepc_value_wen,
  output logic        o_mcause_interrupt,
  output logic        o_mcause_interrupt_wen,
  output logic [30:0] o_mcause_exception_code,
  output logic        o_mcause_exception_code_wen,
  output logic [31:0] o_mtval_value,
  output logic        o_mtval_value_wen,
  output logic        o_mstatus_mie,
  output logic        o_mstatus_mie_wen,
  output logic        o_mstatus_mpie,
  output logic        o_mstatus_mpie_wen,
  output logic [1:0]  o_mstatus_mpp,
  output logic        o_mstatus_mpp_wen,
  output logic        o_busy,
  output logic        o_flush,
  output logic        o_pc_redirect,
  output logic [31:0] o_pc_target
);

  typedef enum logic [1:0] {IDLE, WRITE, REDIRECT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ext_sync, sw_sync, tim_sync;
  logic                   ext_pend, sw_pend, tim_pend, irq_pend;
  logic                   take_exc, take_irq, take_mret;
  logic [3:0]             irq_code;
  logic                   hold_mret;
  logic [31:0]            hold_mepc;
  logic [31:0]            trap_target;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_sync <= '0;
      sw_sync  <= '0;
      tim_sync <= '0;
    end else begin
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], i_external_irq};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0],  i_software_irq};
      tim_sync <= {tim_sync[SYNC_STAGES-2:0], i_timer_irq};
    end
  end

  assign ext_pend = ext_sync[SYNC_STAGES-1] & i_meie & i_mstatus_mie;
  assign sw_pend  = sw_sync[SYNC_STAGES-1]  & i_msie & i_mstatus_mie;
  assign tim_pend = tim_sync[SYNC_STAGES-1] & i_mtie & i_mstatus_mie;
  assign irq_pend = ext_pend | sw_pend | tim_pend;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    irq_code  = 4'd7;
    if (ext_pend)     irq_code = 4'd11;
    else if (sw_pend) irq_code = 4'd3;
    if (i_instr_valid) begin
      if (i_exc_valid)   take_exc  = 1'b1;
      else if (irq_pend) take_irq  = 1'b1;
      else if (i_mret)   take_mret = 1'b1;
    end
  end

`ifdef TRAP_VECTORED_EN
  logic       hold_irq;
  logic [3:0] hold_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_irq  <= 1'b0;
      hold_code <= '0;
    end else if (state == IDLE && (take_exc || take_irq)) begin
      hold_irq  <= take_irq;
      hold_code <= take_irq ? irq_code : i_exc_code;
    end
  end

  // Only interrupts in mode 01 are vectored; modes 10/11 fall back to direct.
  always_comb begin
    trap_target = {i_mtvec_base, 2'b00};
    if (hold_irq && i_mtvec_mode == 2'b01)
      trap_target = {i_mtvec_base, 2'b00} + {26'd0, hold_code, 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = ^i_mtvec_mode;
  assign trap_target = {i_mtvec_base, 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                       <= IDLE;
      hold_mret                   <= 1'b0;
      hold_mepc                   <= '0;
      o_mepc_value                <= '0;
      o_mepc_value_wen            <= 1'b0;
      o_mcause_interrupt          <= 1'b0;
      o_mcause_interrupt_wen      <= 1'b0;
      o_mcause_exception_code     <= '0;
      o_mcause_exception_code_wen <= 1'b0;
      o_mtval_value               <= '0;
      o_mtval_value_wen           <= 1'b0;
      o_mstatus_mie               <= 1'b0;
      o_mstatus_mie_wen           <= 1'b0;
      o_mstatus_mpie              <= 1'b0;
      o_mstatus_mpie_wen          <= 1'b0;
      o_mstatus_mpp               <= 2'b00;
      o_mstatus_mpp_wen           <= 1'b0;
      o_busy                      <= 1'b0;
      o_flush                     <= 1'b0;
      o_pc_redirect               <= 1'b0;
      o_pc_target                 <= '0;
    end else begin
      // Every output is a one-cycle pulse unless the current state re-asserts it.
      o_mepc_value                <= '0;
      o_mepc_value_wen            <= 1'b0;
      o_mcause_interrupt          <= 1'b0;
      o_mcause_interrupt_wen      <= 1'b0;
      o_mcause_exception_code     <= '0;
      o_mcause_exception_code_wen <= 1'b0;
      o_mtval_value               <= '0;
      o_mtval_value_wen           <= 1'b0;
      o_mstatus_mie               <= 1'b0;
      o_mstatus_mie_wen           <= 1'b0;
      o_mstatus_mpie              <= 1'b0;
      o_mstatus_mpie_wen          <= 1'b0;
      o_mstatus_mpp               <= 2'b00;
      o_mstatus_mpp_wen           <= 1'b0;
      o_busy                      <= 1'b0;
      o_flush                     <= 1'b0;
      o_pc_redirect               <= 1'b0;
      o_pc_target                 <= '0;
      case (state)
        IDLE: begin
          if (take_exc || take_irq || take_mret) begin
            state              <= WRITE;
            o_busy             <= 1'b1;
            o_flush            <= 1'b1;
            hold_mret          <= take_mret;
            hold_mepc          <= i_mepc_value;
            o_mstatus_mie_wen  <= 1'b1;
            o_mstatus_mpie_wen <= 1'b1;
            o_mstatus_mpp_wen  <= 1'b1;
            o_mstatus_mpp      <= 2'b11;
            if (take_mret) begin
              o_mstatus_mie  <= i_mstatus_mpie;
              o_mstatus_mpie <= 1'b1;
            end else begin
              o_mstatus_mie               <= 1'b0;
              o_mstatus_mpie              <= i_mstatus_mie;
              o_mepc_value                <= i_instr_pc;
              o_mepc_value_wen            <= 1'b1;
              o_mcause_interrupt          <= take_irq;
              o_mcause_interrupt_wen      <= 1'b1;
              o_mcause_exception_code     <= {27'd0, take_irq ? irq_code : i_exc_code};
              o_mcause_exception_code_wen <= 1'b1;
              o_mtval_value               <= take_irq ? 32'd0 : i_exc_tval;
              o_mtval_value_wen           <= 1'b1;
            end
          end
        end
        WRITE: begin
          state         <= REDIRECT;
          o_busy        <= 1'b1;
          o_pc_redirect <= 1'b1;
          o_pc_target   <= hold_mret ? hold_mepc : trap_target;
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized commits
// checked against a rule-level reference model.
module tb_trap_ctrl;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic [31:0] i_instr_pc = '0;
  logic        i_exc_valid = 1'b0;
  logic [3:0]  i_exc_code = '0;
  logic [31:0] i_exc_tval = '0;
  logic        i_mret = 1'b0;
  logic        i_external_irq = 1'b0, i_software_irq = 1'b0, i_timer_irq = 1'b0;
  logic        i_meie = 1'b0, i_msie = 1'b0, i_mtie = 1'b0;
  logic        i_mstatus_mie = 1'b0, i_mstatus_mpie = 1'b0;
  logic [29:0] i_mtvec_base = '0;
  logic [1:0]  i_mtvec_mode = '0;
  logic [31:0] i_mepc_value = '0;
  logic [31:0] o_mepc_value;
  logic        o_mepc_value_wen;
  logic        o_mcause_interrupt, o_mcause_interrupt_wen;
  logic [30:0] o_mcause_exception_code;
  logic        o_mcause_exception_code_wen;
  logic [31:0] o_mtval_value;
  logic        o_mtval_value_wen;
  logic        o_mstatus_mie, o_mstatus_mie_wen, o_mstatus_mpie, o_mstatus_mpie_wen;
  logic [1:0]  o_mstatus_mpp;
  logic        o_mstatus_mpp_wen;
  logic        o_busy, o_flush, o_pc_redirect;
  logic [31:0] o_pc_target;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        exc;
    logic [3:0]  code;
    logic [31:0] tval;
    logic        mret;
    logic        ext, sw, tim;
    logic        meie, msie, mtie;
    logic        mie, mpie;
    logic [29:0] base;
    logic [1:0]  mode;
    logic [31:0] mepc;
  } stim_t;

  trap_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(i_instr_valid), .i_instr_pc(i_instr_pc),
    .i_exc_valid(i_exc_valid), .i_exc_code(i_exc_code), .i_exc_tval(i_exc_tval),
    .i_mret(i_mret),
    .i_external_irq(i_external_irq), .i_software_irq(i_software_irq), .i_timer_irq(i_timer_irq),
    .i_meie(i_meie), .i_msie(i_msie), .i_mtie(i_mtie),
    .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
    .i_mtvec_base(i_mtvec_base), .i_mtvec_mode(i_mtvec_mode), .i_mepc_value(i_mepc_value),
    .o_mepc_value(o_mepc_value), .o_mepc_value_wen(o_mepc_value_wen),
    .o_mcause_interrupt(o_mcause_interrupt), .o_mcause_interrupt_wen(o_mcause_interrupt_wen),
    .o_mcause_exception_code(o_mcause_exception_code),
    .o_mcause_exception_code_wen(o_mcause_exception_code_wen),
    .o_mtval_value(o_mtval_value), .o_mtval_value_wen(o_mtval_value_wen),
    .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mie_wen(o_mstatus_mie_wen),
    .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpie_wen(o_mstatus_mpie_wen),
    .o_mstatus_mpp(o_mstatus_mpp), .o_mstatus_mpp_wen(o_mstatus_mpp_wen),
    .o_busy(o_busy), .o_flush(o_flush),
    .o_pc_redirect(o_pc_redirect), .o_pc_target(o_pc_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, ".flush"}, {31'd0, o_flush}, 32'd0);
    check({tag, ".redirect"}, {31'd0, o_pc_redirect}, 32'd0);
    check({tag, ".wens"}, {26'd0, o_mepc_value_wen, o_mcause_interrupt_wen,
           o_mcause_exception_code_wen, o_mtval_value_wen, o_mstatus_mie_wen,
           o_mstatus_mpp_wen}, 32'd0);
  endtask

  // Applies one commit after letting the irq lines settle through the synchronizers,
  // then checks the whole WRITE/REDIRECT sequence against rule-level expectations.
  task automatic do_commit(input string tag, input stim_t s);
    int          kind;   // 0 none, 1 trap, 2 mret
    logic        is_irq;
    logic [3:0]  code;
    logic [31:0] tval;
    logic [31:0] target;
    i_external_irq = s.ext;  i_software_irq = s.sw;  i_timer_irq = s.tim;
    i_meie = s.meie;  i_msie = s.msie;  i_mtie = s.mtie;
    i_mstatus_mie = s.mie;  i_mstatus_mpie = s.mpie;
    i_mtvec_base = s.base;  i_mtvec_mode = s.mode;  i_mepc_value = s.mepc;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    i_instr_valid = 1'b1;  i_instr_pc = s.pc;
    i_exc_valid = s.exc;  i_exc_code = s.code;  i_exc_tval = s.tval;  i_mret = s.mret;

    kind = 0;  is_irq = 1'b0;  code = 4'd0;  tval = 32'd0;
    if (s.exc) begin
      kind = 1;  code = s.code;  tval = s.tval;
    end else if (s.mie && s.ext && s.meie) begin
      kind = 1;  is_irq = 1'b1;  code = 4'd11;
    end else if (s.mie && s.sw && s.msie) begin
      kind = 1;  is_irq = 1'b1;  code = 4'd3;
    end else if (s.mie && s.tim && s.mtie) begin
      kind = 1;  is_irq = 1'b1;  code = 4'd7;
    end else if (s.mret) begin
      kind = 2;
    end
    target = (kind == 2) ? s.mepc : s.base * 4;
`ifdef TRAP_VECTORED_EN
    if (kind == 1 && is_irq && s.mode == 2'b01) target = s.base * 4 + code * 4;
`endif

    @(posedge clk);
    #1;
    i_instr_valid = 1'b0;  i_exc_valid = 1'b0;  i_mret = 1'b0;
    if (kind == 0) begin
      check_quiet({tag, ".none"});
      return;
    end
    check({tag, ".w.flush"}, {31'd0, o_flush}, 32'd1);
    check({tag, ".w.busy"}, {31'd0, o_busy}, 32'd1);
    check({tag, ".w.redirect"}, {31'd0, o_pc_redirect}, 32'd0);
    check({tag, ".w.mst_wens"}, {29'd0, o_mstatus_mie_wen, o_mstatus_mpie_wen, o_mstatus_mpp_wen}, 32'd7);
    check({tag, ".w.mpp"}, {30'd0, o_mstatus_mpp}, 32'd3);
    if (kind == 1) begin
      check({tag, ".w.trap_wens"}, {28'd0, o_mepc_value_wen, o_mcause_interrupt_wen,
             o_mcause_exception_code_wen, o_mtval_value_wen}, 32'hF);
      check({tag, ".w.mepc"}, o_mepc_value, s.pc);
      check({tag, ".w.mcause"}, {o_mcause_interrupt, o_mcause_exception_code}, {is_irq, 27'd0, code});
      check({tag, ".w.mtval"}, o_mtval_value, tval);
      check({tag, ".w.mie"}, {31'd0, o_mstatus_mie}, 32'd0);
      check({tag, ".w.mpie"}, {31'd0, o_mstatus_mpie}, {31'd0, s.mie});
    end else begin
      check({tag, ".w.trap_wens"}, {28'd0, o_mepc_value_wen, o_mcause_interrupt_wen,
             o_mcause_exception_code_wen, o_mtval_value_wen}, 32'h0);
      check({tag, ".w.mie"}, {31'd0, o_mstatus_mie}, {31'd0, s.mpie});
      check({tag, ".w.mpie"}, {31'd0, o_mstatus_mpie}, 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, ".r.redirect"}, {31'd0, o_pc_redirect}, 32'd1);
    check({tag, ".r.target"}, o_pc_target, target);
    check({tag, ".r.busy"}, {31'd0, o_busy}, 32'd1);
    check({tag, ".r.flush"}, {31'd0, o_flush}, 32'd0);
    check({tag, ".r.mst_wen"}, {31'd0, o_mstatus_mie_wen}, 32'd0);
    @(posedge clk);
    #1;
    check_quiet({tag, ".idle"});
  endtask

  function automatic stim_t base_stim();
    stim_t s;
    s = '{pc: 32'h0, exc: 1'b0, code: 4'd0, tval: 32'h0, mret: 1'b0,
          ext: 1'b0, sw: 1'b0, tim: 1'b0, meie: 1'b0, msie: 1'b0, mtie: 1'b0,
          mie: 1'b1, mpie: 1'b0, base: 30'h200, mode: 2'b00, mepc: 32'h0};
    return s;
  endfunction

  initial begin
    stim_t s;
    #22;
    check_quiet("reset");
    check("reset.target", o_pc_target, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);

    // Illegal instruction exception.
    s = base_stim();
    s.exc = 1'b1;  s.code = 4'd2;  s.pc = 32'h100;  s.tval = 32'hDEAD;
    do_commit("illegal", s);

    // Timer interrupt, vectored mode requested.
    s = base_stim();
    s.tim = 1'b1;  s.mtie = 1'b1;  s.pc = 32'h40;  s.mode = 2'b01;
    do_commit("timer", s);

    // mret back to mepc.
    s = base_stim();
    s.mret = 1'b1;  s.mepc = 32'h44;  s.mpie = 1'b1;  s.mie = 1'b0;
    do_commit("mret", s);

    // Exception beats pending external+timer; then external beats timer.
    s = base_stim();
    s.ext = 1'b1;  s.tim = 1'b1;  s.meie = 1'b1;  s.mtie = 1'b1;
    s.exc = 1'b1;  s.code = 4'd5;  s.pc = 32'h300;  s.tval = 32'h1234;
    do_commit("exc_over_irq", s);
    s.exc = 1'b0;  s.pc = 32'h304;  s.mode = 2'b01;
    do_commit("ext_over_tim", s);

    // Exception beats mret in the same cycle.
    s = base_stim();
    s.exc = 1'b1;  s.mret = 1'b1;  s.code = 4'd11;  s.pc = 32'h500;  s.mepc = 32'h999;
    do_commit("exc_over_mret", s);

    // Pending irq masked by mie=0, then taken once mie rises.
    s = base_stim();
    s.tim = 1'b1;  s.mtie = 1'b1;  s.mie = 1'b0;  s.pc = 32'h600;
    do_commit("masked", s);
    s.mie = 1'b1;
    do_commit("unmasked", s);

    // Masked irq does not block mret.
    s = base_stim();
    s.sw = 1'b1;  s.msie = 1'b1;  s.mie = 1'b0;  s.mret = 1'b1;  s.mepc = 32'hFFFF_FFFC;
    do_commit("mret_masked_irq", s);

    // exc/mret without a valid commit are ignored.
    i_external_irq = 1'b0;  i_software_irq = 1'b0;  i_timer_irq = 1'b0;
    #1;
    i_exc_valid = 1'b1;  i_mret = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("no_valid");
    i_exc_valid = 1'b0;  i_mret = 1'b0;

    // Reset during WRITE abandons the sequence.
    i_mstatus_mie = 1'b1;
    i_instr_valid = 1'b1;  i_exc_valid = 1'b1;  i_exc_code = 4'd4;  i_instr_pc = 32'h700;
    @(posedge clk);
    #1;
    i_instr_valid = 1'b0;  i_exc_valid = 1'b0;
    check("rst.pre_flush", {31'd0, o_flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("rst.after1");
    @(posedge clk);
    #1;
    check_quiet("rst.after2");

    // Randomized commits.
    for (int i = 0; i < 40; i++) begin
      s.pc   = $urandom;
      s.exc  = ($urandom_range(0, 3) == 0);
      s.code = 4'($urandom);
      s.tval = $urandom;
      s.mret = ($urandom_range(0, 2) == 0);
      s.ext  = 1'($urandom);  s.sw = 1'($urandom);  s.tim = 1'($urandom);
      s.meie = 1'($urandom);  s.msie = 1'($urandom);  s.mtie = 1'($urandom);
      s.mie  = 1'($urandom);  s.mpie = 1'($urandom);
      s.base = 30'($urandom);
      s.mode = 2'($urandom);
      s.mepc = $urandom;
      do_commit($sformatf("rand%0d", i), s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
